// File: rtl/elevator_scheduler.sv
// SCAN request scheduler and door sequencer for a 3-floor car.
// Latches cab requests, issues one travel goal at a time and times the door dwell.
module elevator_scheduler #(
  parameter logic [1:0]  LF1        = 2'b00,
  parameter logic [1:0]  LF2        = 2'b01,
  parameter logic [1:0]  LF3        = 2'b10,
  parameter int unsigned DOOR_TICKS = 2
) (
  input  logic       door_clk,
  input  logic       button_reset,
  input  logic [2:0] req,
  input  logic [1:0] floor_in,
  input  logic       moving,
  input  logic       sos_mode,
  input  logic       weight_limit_exceeded,
  output logic [1:0] goal_floor,
  output logic       goal_valid,
  output logic       dir_up,
  output logic       door_open,
  output logic [2:0] pending,
  output logic [2:0] state
);

  localparam int unsigned CntW = $clog2(DOOR_TICKS + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(DOOR_TICKS - 1);

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StSelect   = 3'd1,
    StTravel   = 3'd2,
    StDoorOpen = 3'd3,
    StHalt     = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic [1:0]      goal_q, goal_d;
  logic            dir_q, dir_d;
  logic [2:0]      pending_q, pending_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic [2:0] floor_oh;
  logic       floor_ok;
  logic       pend_here;
  logic       req_here;
  logic [2:0] up_oh, dn_oh, sel_oh;
  logic       eff_up, sel_up;
  logic [1:0] sel_goal;

  function automatic logic [1:0] oh_to_lf(input logic [2:0] oh);
    logic [1:0] lf;
    lf = LF1;
    if (oh[2]) begin
      lf = LF3;
    end else if (oh[1]) begin
      lf = LF2;
    end
    return lf;
  endfunction

  // Car position as a one-hot mask aligned with req/pending; all-zero when invalid.
  assign floor_oh  = {floor_in == LF3, floor_in == LF2, floor_in == LF1};
  assign floor_ok  = |floor_oh;
  assign pend_here = |(pending_q & floor_oh);
  assign req_here  = |(req & floor_oh);

  // Nearest pending floor strictly above / below the car.
  always_comb begin
    up_oh = 3'b000;
    dn_oh = 3'b000;
    if (floor_oh[0]) begin
      if (pending_q[1]) begin
        up_oh = 3'b010;
      end else if (pending_q[2]) begin
        up_oh = 3'b100;
      end
    end else if (floor_oh[1] && pending_q[2]) begin
      up_oh = 3'b100;
    end
    if (floor_oh[2]) begin
      if (pending_q[1]) begin
        dn_oh = 3'b010;
      end else if (pending_q[0]) begin
        dn_oh = 3'b001;
      end
    end else if (floor_oh[1] && pending_q[0]) begin
      dn_oh = 3'b001;
    end
  end

  // SCAN choice: keep direction while something lies ahead, otherwise reverse.
  always_comb begin
    eff_up = dir_q;
    if (floor_oh[2]) begin
      eff_up = 1'b0;
    end else if (floor_oh[0]) begin
      eff_up = 1'b1;
    end
    sel_up = eff_up;
    sel_oh = 3'b000;
    if (eff_up) begin
      if (|up_oh) begin
        sel_oh = up_oh;
      end else begin
        sel_oh = dn_oh;
        sel_up = 1'b0;
      end
    end else begin
      if (|dn_oh) begin
        sel_oh = dn_oh;
      end else begin
        sel_oh = up_oh;
        sel_up = 1'b1;
      end
    end
    sel_goal = oh_to_lf(sel_oh);
  end

  // A held button re-sets its bit after the door clears it.
  always_comb begin
    pending_d = pending_q;
    if (state_q == StDoorOpen) begin
      pending_d = pending_q & ~floor_oh;
    end
    pending_d = pending_d | req;
  end

  always_comb begin
    state_d = state_q;
    goal_d  = goal_q;
    dir_d   = dir_q;
    cnt_d   = '0;
    if (sos_mode) begin
      state_d = StHalt;
    end else begin
      case (state_q)
        StIdle: begin
          if (floor_ok) begin
            goal_d = floor_in;
            if (pend_here) begin
              state_d = StDoorOpen;
            end else if ((|pending_q) && !weight_limit_exceeded && !moving) begin
              state_d = StSelect;
            end
          end
        end
        StSelect: begin
          if (weight_limit_exceeded || !(|sel_oh)) begin
            state_d = StIdle;
          end else begin
            goal_d  = sel_goal;
            dir_d   = sel_up;
            state_d = StTravel;
          end
        end
        StTravel: begin
          if ((floor_in == goal_q) && !moving) begin
            state_d = StDoorOpen;
          end
        end
        StDoorOpen: begin
          if (weight_limit_exceeded || req_here) begin
            cnt_d = '0;
          end else if (cnt_q == CntLast) begin
            state_d = StIdle;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        StHalt: begin
          state_d = StIdle;
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge door_clk or posedge button_reset) begin
    if (button_reset) begin
      state_q   <= StIdle;
      goal_q    <= LF1;
      dir_q     <= 1'b1;
      pending_q <= 3'b000;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      goal_q    <= goal_d;
      dir_q     <= dir_d;
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
    end
  end

  assign goal_floor = goal_q;
  assign goal_valid = (state_q == StTravel);
  assign door_open  = (state_q == StDoorOpen);
  assign dir_up     = dir_q;
  assign pending    = pending_q;
  assign state      = state_q;

endmodule

// File: tb/tb_elevator_scheduler.sv
// Directed bench for elevator_scheduler: floor-level behavioural model checked every cycle,
// plus hand-computed expectations at key points.
module tb_elevator_scheduler;

  localparam int DT = 2;

  logic       door_clk;
  logic       button_reset;
  logic [2:0] req;
  logic [1:0] floor_in;
  logic       moving;
  logic       sos_mode;
  logic       weight_limit_exceeded;
  logic [1:0] goal_floor;
  logic       goal_valid;
  logic       dir_up;
  logic       door_open;
  logic [2:0] pending;
  logic [2:0] state;

  elevator_scheduler #(
    .LF1       (2'b00),
    .LF2       (2'b01),
    .LF3       (2'b10),
    .DOOR_TICKS(DT)
  ) dut (
    .door_clk             (door_clk),
    .button_reset         (button_reset),
    .req                  (req),
    .floor_in             (floor_in),
    .moving               (moving),
    .sos_mode             (sos_mode),
    .weight_limit_exceeded(weight_limit_exceeded),
    .goal_floor           (goal_floor),
    .goal_valid           (goal_valid),
    .dir_up               (dir_up),
    .door_open            (door_open),
    .pending              (pending),
    .state                (state)
  );

  initial door_clk = 1'b0;
  always #5 door_clk = ~door_clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  // Model: floors numbered 1..3, phase 0 idle,1 select,2 travel,3 door,4 halt.
  int       m_phase;
  int       m_goal;
  bit       m_up;
  bit [2:0] m_pend;
  int       m_left;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int floor_num(input logic [1:0] f);
    case (f)
      2'b00:   return 1;
      2'b01:   return 2;
      2'b10:   return 3;
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    m_phase = 0;
    m_goal  = 1;
    m_up    = 1'b1;
    m_pend  = 3'b000;
    m_left  = 0;
  endtask

  task automatic model_update();
    int       f;
    int       g;
    bit [2:0] np;
    bit       up;
    bit       found;
    f  = floor_num(floor_in);
    g  = 0;
    np = m_pend;
    if (m_phase == 3 && f != 0) np[2'(f - 1)] = 1'b0;
    np = np | req;
    if (sos_mode) begin
      m_phase = 4;
    end else begin
      case (m_phase)
        0: begin
          if (f != 0) begin
            m_goal = f;
            if (m_pend[2'(f - 1)]) begin
              m_phase = 3;
              m_left  = DT;
            end else if (m_pend != 3'b000 && !weight_limit_exceeded && !moving) begin
              m_phase = 1;
            end
          end
        end
        1: begin
          m_phase = 0;
          if (!weight_limit_exceeded && f != 0) begin
            up = (f == 3) ? 1'b0 : (f == 1) ? 1'b1 : m_up;
            found = 1'b0;
            for (int pass = 0; pass < 2 && !found; pass++) begin
              for (int d = 1; d <= 2 && !found; d++) begin
                g = up ? f + d : f - d;
                if (g >= 1 && g <= 3 && m_pend[2'(g - 1)]) found = 1'b1;
              end
              if (!found) up = !up;
            end
            if (found) begin
              m_goal  = g;
              m_up    = up;
              m_phase = 2;
            end
          end
        end
        2: begin
          if (f == m_goal && !moving) begin
            m_phase = 3;
            m_left  = DT;
          end
        end
        3: begin
          if (weight_limit_exceeded || (f != 0 && req[2'(f - 1)])) begin
            m_left = DT;
          end else begin
            m_left--;
            if (m_left == 0) m_phase = 0;
          end
        end
        default: m_phase = 0;
      endcase
    end
    m_pend = np;
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge door_clk);
      if (button_reset) model_reset();
      else model_update();
      @(negedge door_clk);
      #1;
    end
  endtask

  task automatic wait_state(input int code, input int budget, input string name);
    int k;
    k = 0;
    while (int'(state) != code && k < budget) begin
      cyc(1);
      k++;
    end
    check(name, int'(state), code);
  endtask

  always @(negedge door_clk) begin
    if (chk_en) begin
      check("cmp_goal_floor", int'(goal_floor), m_goal - 1);
      check("cmp_goal_valid", int'(goal_valid), int'(m_phase == 2));
      check("cmp_door_open", int'(door_open), int'(m_phase == 3));
      check("cmp_dir_up", int'(dir_up), int'(m_up));
      check("cmp_pending", int'(pending), int'(m_pend));
      check("cmp_state", int'(state), m_phase);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_open;
    button_reset          = 1'b1;
    req                   = 3'b000;
    floor_in              = 2'b00;
    moving                = 1'b0;
    sos_mode              = 1'b0;
    weight_limit_exceeded = 1'b0;
    model_reset();
    chk_en = 1'b1;
    cyc(2);
    check("rst_state", int'(state), 0);
    check("rst_goal_valid", int'(goal_valid), 0);
    check("rst_door_open", int'(door_open), 0);
    check("rst_dir_up", int'(dir_up), 1);
    check("rst_pending", int'(pending), 0);
    check("rst_goal_floor", int'(goal_floor), 0);
    button_reset = 1'b0;
    cyc(1);

    // Remote request from LF1 to LF3.
    req = 3'b100;
    cyc(1);
    req = 3'b000;
    check("b_latch_pending", int'(pending), 4);
    check("b_latch_state", int'(state), 0);
    cyc(1);
    check("b_select_state", int'(state), 1);
    cyc(1);
    check("b_goal_floor", int'(goal_floor), 2);
    check("b_goal_valid", int'(goal_valid), 1);
    moving = 1'b1;
    cyc(2);
    check("b_still_travel", int'(goal_valid), 1);
    floor_in = 2'b10;
    cyc(1);
    moving = 1'b0;
    cyc(1);
    check("b_door_entry", int'(door_open), 1);
    check("b_goal_dropped", int'(goal_valid), 0);
    n_open = 0;
    for (int k = 0; k < 20; k++) begin
      if (!door_open) break;
      n_open++;
      cyc(1);
    end
    check("b_door_cycles", n_open, DT);
    check("b_pending_clear", int'(pending), 0);
    check("b_back_idle", int'(state), 0);

    // LF2, dir up, only LF1 pending: direction reverses.
    floor_in = 2'b01;
    cyc(1);
    req = 3'b001;
    cyc(1);
    req = 3'b000;
    cyc(2);
    check("c_dir_reversed", int'(dir_up), 0);
    check("c_goal_lf1", int'(goal_floor), 0);
    check("c_goal_valid", int'(goal_valid), 1);
    floor_in = 2'b00;
    cyc(1);
    check("c_door", int'(door_open), 1);
    wait_state(0, 10, "c_idle");

    // LF1 -> LF2 to get dir up at LF2, then pending 101 serves LF3 first.
    req = 3'b010;
    cyc(1);
    req = 3'b000;
    cyc(2);
    check("d_goal_lf2", int'(goal_floor), 1);
    check("d_dir_up", int'(dir_up), 1);
    floor_in = 2'b01;
    cyc(1);
    wait_state(0, 10, "d_idle_lf2");
    req = 3'b101;
    cyc(1);
    req = 3'b000;
    cyc(2);
    check("d_goal_lf3_first", int'(goal_floor), 2);
    check("d_pending_101", int'(pending), 5);
    floor_in = 2'b10;
    cyc(1);
    wait_state(0, 10, "d_idle_lf3");
    cyc(2);
    check("d_goal_lf1_second", int'(goal_floor), 0);
    check("d_dir_down", int'(dir_up), 0);
    check("d_goal_valid", int'(goal_valid), 1);
    floor_in = 2'b00;
    cyc(1);
    wait_state(0, 10, "d_idle_lf1");

    // Own-floor request opens in two edges; overload holds the door for 5 cycles.
    req = 3'b001;
    cyc(1);
    req = 3'b000;
    cyc(1);
    check("e_door_latency", int'(door_open), 1);
    n_open = 0;
    for (int k = 0; k < 30; k++) begin
      if (!door_open) break;
      n_open++;
      weight_limit_exceeded = (n_open <= 5);
      req = (n_open == 2) ? 3'b010 : 3'b000;
      cyc(1);
    end
    weight_limit_exceeded = 1'b0;
    req = 3'b000;
    check("e_door_hold_cycles", n_open, 5 + DT);
    check("e_pending_010", int'(pending), 2);
    cyc(2);
    check("e_travel_lf2", int'(goal_floor), 1);
    check("e_travel_valid", int'(goal_valid), 1);

    // SOS during travel.
    sos_mode = 1'b1;
    cyc(1);
    check("f_halt_state", int'(state), 4);
    check("f_halt_goal_valid", int'(goal_valid), 0);
    check("f_halt_pending", int'(pending), 2);
    cyc(2);
    check("f_halt_held", int'(state), 4);
    sos_mode = 1'b0;
    cyc(1);
    check("f_release_idle", int'(state), 0);
    cyc(2);
    check("f_reissue_valid", int'(goal_valid), 1);
    check("f_reissue_goal", int'(goal_floor), 1);
    floor_in = 2'b01;
    cyc(1);
    wait_state(0, 10, "f_idle");

    // Invalid floor holds IDLE; held button keeps door and pending bit.
    floor_in = 2'b11;
    req = 3'b001;
    cyc(1);
    req = 3'b000;
    cyc(3);
    check("g_invalid_idle", int'(state), 0);
    check("g_invalid_pending", int'(pending), 1);
    check("g_invalid_goal", int'(goal_floor), 1);
    floor_in = 2'b00;
    cyc(1);
    check("g_door", int'(door_open), 1);
    req = 3'b001;
    cyc(3);
    check("g_held_door", int'(door_open), 1);
    check("g_held_pending", int'(pending), 1);
    req = 3'b000;
    wait_state(0, 10, "g_idle");
    check("g_pending_clear", int'(pending), 0);

    // Asynchronous reset in the middle of travel to LF3.
    req = 3'b100;
    cyc(1);
    req = 3'b000;
    cyc(2);
    check("h_goal_lf3", int'(goal_floor), 2);
    moving = 1'b1;
    cyc(1);
    button_reset = 1'b1;
    #1;
    check("h_rst_goal_valid", int'(goal_valid), 0);
    check("h_rst_door_open", int'(door_open), 0);
    check("h_rst_pending", int'(pending), 0);
    check("h_rst_state", int'(state), 0);
    check("h_rst_dir_up", int'(dir_up), 1);
    check("h_rst_goal_floor", int'(goal_floor), 0);
    model_reset();
    cyc(2);
    moving = 1'b0;
    button_reset = 1'b0;
    cyc(1);
    check("h_after_reset_idle", int'(state), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
